// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants, the writeback packet type and a round-robin helper
// for the writeback port arbiter slice.
package wb_port_arbiter_pkg;

    localparam int NUM_WB_REQ       = 4;
    localparam int WB_ARB_BUF_DEPTH = 2;

    typedef struct packed {
        logic        valid;
        logic [5:0]  seqNo;
        logic [4:0]  dest_reg;
        logic [31:0] data;
    } wbPkt;

    // Lane visited 'offset' steps after 'base' in a ring of 'num_req' lanes.
    function automatic int rr_lane(input int base, input int offset, input int num_req);
        return (base + offset) % num_req;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of per-lane writeback requests, flow control and the shared
// arbitrated output; 'master' is the producer side, 'slave' the arbiter.
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = NUM_WB_REQ,
    parameter int BUF_DEPTH = WB_ARB_BUF_DEPTH
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic               recoverFlag_i;
    wbPkt               wbPacket_i [NUM_REQ];
    logic [NUM_REQ-1:0] ready_o;
    wbPkt               wbPacket_o;
    logic [NUM_REQ-1:0] grant_o;
    logic [CNT_W-1:0]   occupancy_o [NUM_REQ];

    modport master (
        output recoverFlag_i,
        output wbPacket_i,
        input  ready_o,
        input  wbPacket_o,
        input  grant_o,
        input  occupancy_o
    );

    modport slave (
        input  recoverFlag_i,
        input  wbPacket_i,
        output ready_o,
        output wbPacket_o,
        output grant_o,
        output occupancy_o
    );

endinterface

// File: rtl/wb_arb_fifo.sv
// Per-lane skid FIFO of writeback packets with fill count, synchronous
// flush and asynchronous reset; DEPTH must be a power of two.
module wb_arb_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int  DEPTH = WB_ARB_BUF_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  wbPkt             push_pkt,
    input  logic             pop,
    output wbPkt             head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    wbPkt             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_pkt;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: one skid FIFO per functional-unit lane feeding a
// round-robin pick that is registered onto the single writeback port.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = NUM_WB_REQ,
    parameter int BUF_DEPTH = WB_ARB_BUF_DEPTH
) (
    input logic              clk,
    input logic              reset,
    wb_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    wbPkt               head_pkt  [NUM_REQ];
    logic [CNT_W-1:0]   occupancy [NUM_REQ];
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] drop;
    logic [NUM_REQ-1:0] non_empty;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;
    logic               sel_valid;

    // Ready looks only at stored state, so a full lane stays not-ready even
    // while its head is being drained.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign ready[g]     = (occupancy[g] < CNT_W'(BUF_DEPTH));
        assign non_empty[g] = (occupancy[g] != '0);
        assign push[g]      = bus.wbPacket_i[g].valid & ready[g] & ~bus.recoverFlag_i;
        assign drop[g]      = bus.wbPacket_i[g].valid & ~ready[g] & ~bus.recoverFlag_i;
        assign pop[g]       = sel_onehot[g] & ~bus.recoverFlag_i;
        assign bus.occupancy_o[g] = occupancy[g];

        wb_arb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .flush    (bus.recoverFlag_i),
            .push     (push[g]),
            .push_pkt (bus.wbPacket_i[g]),
            .pop      (pop[g]),
            .head     (head_pkt[g]),
            .count    (occupancy[g])
        );
    end

    assign bus.ready_o = ready;

    // Search starts one past the last granted lane.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'(rr_lane(int'(rr_ptr), k, NUM_REQ));
            if (!sel_valid && non_empty[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign sel_onehot = sel_valid ? (NUM_REQ'(1) << sel_idx) : '0;

    // Recovery kills the output but keeps rr_ptr, so fairness survives a flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr         <= IDX_W'(NUM_REQ - 1);
            bus.wbPacket_o <= '0;
            bus.grant_o    <= '0;
        end else if (bus.recoverFlag_i) begin
            bus.wbPacket_o <= '0;
            bus.grant_o    <= '0;
        end else if (sel_valid) begin
            bus.wbPacket_o <= head_pkt[sel_idx];
            bus.grant_o    <= sel_onehot;
            rr_ptr         <= sel_idx;
        end else begin
            bus.wbPacket_o <= '0;
            bus.grant_o    <= '0;
        end
    end

`ifndef SYNTHESIS
    no_drop_a: assert property (@(posedge clk) disable iff (reset) drop == '0)
        else $warning("wb_port_arbiter: packet dropped on non-ready lane mask %b", drop);
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scenario and randomized bench for wb_port_arbiter, scored against a
// queue-based round-robin model of the writeback arbiter.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int D  = 2;
    localparam int CW = $clog2(D + 1);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   pass_count  = 0;
    int   check_count = 0;

    wbPkt         m_q [N][$];
    int           m_rr;
    wbPkt         m_out;
    logic [N-1:0] m_grant;

    wb_port_arbiter_if #(.NUM_REQ(N), .BUF_DEPTH(D)) bus ();

    wb_port_arbiter #(.NUM_REQ(N), .BUF_DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic wbPkt mk(input int seq, input int lane);
        wbPkt p;
        p.valid    = 1'b1;
        p.seqNo    = 6'(seq);
        p.dest_reg = 5'(lane);
        p.data     = 32'hA500_0000 | 32'(seq * 16 + lane);
        return p;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) bus.wbPacket_i[i] = '0;
        bus.recoverFlag_i = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_q[i].delete();
        m_rr    = N - 1;
        m_out   = '0;
        m_grant = '0;
    endtask

    // One clock edge of the arbiter: pick from the pre-edge queues, then
    // accept inputs on lanes that were not full before the edge.
    task automatic model_step();
        int sizes [N];
        int win;
        for (int i = 0; i < N; i++) sizes[i] = m_q[i].size();
        if (bus.recoverFlag_i) begin
            for (int i = 0; i < N; i++) m_q[i].delete();
            m_out   = '0;
            m_grant = '0;
        end else begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
                if (win < 0 && sizes[(m_rr + k) % N] > 0) win = (m_rr + k) % N;
            end
            m_grant = '0;
            if (win >= 0) begin
                m_out        = m_q[win].pop_front();
                m_grant[win] = 1'b1;
                m_rr         = win;
            end else begin
                m_out = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.wbPacket_i[i].valid && sizes[i] < D) m_q[i].push_back(bus.wbPacket_i[i]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        check_count++;
        if (bus.wbPacket_o !== '0) $display("[TB] FAIL reset_pkt: got %h want 0", bus.wbPacket_o);
        else pass_count++;
        check_count++;
        if (bus.grant_o !== 4'b0000) $display("[TB] FAIL reset_grant: got %b want 0000", bus.grant_o);
        else pass_count++;
        check_count++;
        if (bus.ready_o !== 4'b1111) $display("[TB] FAIL reset_ready: got %b want 1111", bus.ready_o);
        else pass_count++;
        for (int i = 0; i < N; i++) begin
            check_count++;
            if (bus.occupancy_o[i] !== CW'(0)) $display("[TB] FAIL reset_occ%0d: got %0d want 0", i, bus.occupancy_o[i]);
            else pass_count++;
        end
        reset = 1'b0;
        tick();
        check_count++;
        if (bus.wbPacket_o.valid !== 1'b0) $display("[TB] FAIL reset_idle: got valid %b want 0", bus.wbPacket_o.valid);
        else pass_count++;
    endtask

    task automatic test_single_latency();
        do_reset();
        repeat (3) tick();
        bus.wbPacket_i[2] = mk(5, 2);
        tick();
        clear_inputs();
        check_count++;
        if (bus.wbPacket_o.valid !== 1'b0) $display("[TB] FAIL single_early: got valid %b want 0", bus.wbPacket_o.valid);
        else pass_count++;
        check_count++;
        if (bus.occupancy_o[2] !== CW'(1)) $display("[TB] FAIL single_occ: got %0d want 1", bus.occupancy_o[2]);
        else pass_count++;
        tick();
        check_count++;
        if (bus.wbPacket_o !== mk(5, 2)) $display("[TB] FAIL single_pkt: got %h want %h", bus.wbPacket_o, mk(5, 2));
        else pass_count++;
        check_count++;
        if (bus.grant_o !== 4'b0100) $display("[TB] FAIL single_grant: got %b want 0100", bus.grant_o);
        else pass_count++;
        tick();
        check_count++;
        if (bus.wbPacket_o !== '0 || bus.grant_o !== 4'b0000)
            $display("[TB] FAIL single_idle: got %h/%b want 0/0000", bus.wbPacket_o, bus.grant_o);
        else pass_count++;
    endtask

    task automatic test_all_lanes();
        logic [N-1:0] want;
        do_reset();
        for (int i = 0; i < N; i++) bus.wbPacket_i[i] = mk(10 + i, i);
        tick();
        clear_inputs();
        tick();
        for (int j = 0; j < N; j++) begin
            want = 4'b0001 << j;
            check_count++;
            if (bus.wbPacket_o.seqNo !== 6'(10 + j) || bus.grant_o !== want)
                $display("[TB] FAIL all_lanes_%0d: got seq %0d grant %b want seq %0d grant %b",
                         j, bus.wbPacket_o.seqNo, bus.grant_o, 10 + j, want);
            else pass_count++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int next_seq = 20;
        int waited = 0;
        int prev_occ = 0;
        bit second;
        do_reset();
        for (int cyc = 0; cyc < 24; cyc++) begin
            clear_inputs();
            second = 1'b0;
            if (m_q[0].size() < D) bus.wbPacket_i[0] = mk(cyc % 16, 0);
            if (m_q[2].size() < D) bus.wbPacket_i[2] = mk(cyc % 16, 2);
            if (sent < 3 && m_q[1].size() < D) begin
                bus.wbPacket_i[1] = mk(20 + sent, 1);
                sent++;
                second = (sent == 2);
            end
            tick();
            if (second) begin
                check_count++;
                if (bus.ready_o[1] !== 1'b0) $display("[TB] FAIL bp_ready1: got %b want 0", bus.ready_o[1]);
                else pass_count++;
            end
            check_count++;
            if (bus.wbPacket_o !== m_out || bus.grant_o !== m_grant)
                $display("[TB] FAIL bp_out: got %h/%b want %h/%b", bus.wbPacket_o, bus.grant_o, m_out, m_grant);
            else pass_count++;
            if (prev_occ > 0) begin
                if (bus.grant_o[1] === 1'b1) begin
                    check_count++;
                    if (bus.wbPacket_o.seqNo !== 6'(next_seq))
                        $display("[TB] FAIL bp_order: got seq %0d want %0d", bus.wbPacket_o.seqNo, next_seq);
                    else pass_count++;
                    check_count++;
                    if (waited >= N) $display("[TB] FAIL bp_starve: got wait %0d want < %0d", waited, N);
                    else pass_count++;
                    next_seq++;
                    waited = 0;
                end else begin
                    waited++;
                end
            end
            prev_occ = int'(bus.occupancy_o[1]);
        end
        clear_inputs();
        check_count++;
        if (next_seq !== 23) $display("[TB] FAIL bp_count: got next seq %0d want 23", next_seq);
        else pass_count++;
    endtask

    task automatic test_recovery();
        int want_occ [N] = '{2, 1, 2, 0};
        do_reset();
        tick();
        for (int c = 1; c < 4; c++) begin
            clear_inputs();
            for (int l = 0; l < 3; l++) if (m_q[l].size() < D) bus.wbPacket_i[l] = mk(c * 4 + l, l);
            tick();
        end
        for (int i = 0; i < N; i++) begin
            check_count++;
            if (bus.occupancy_o[i] !== CW'(want_occ[i]))
                $display("[TB] FAIL rec_pre_occ%0d: got %0d want %0d", i, bus.occupancy_o[i], want_occ[i]);
            else pass_count++;
        end
        for (int l = 0; l < 3; l++) bus.wbPacket_i[l] = mk(50 + l, l);
        bus.recoverFlag_i = 1'b1;
        tick();
        clear_inputs();
        check_count++;
        if (bus.wbPacket_o !== '0 || bus.grant_o !== 4'b0000)
            $display("[TB] FAIL rec_out: got %h/%b want 0/0000", bus.wbPacket_o, bus.grant_o);
        else pass_count++;
        check_count++;
        if (bus.ready_o !== 4'b1111) $display("[TB] FAIL rec_ready: got %b want 1111", bus.ready_o);
        else pass_count++;
        for (int i = 0; i < N; i++) begin
            check_count++;
            if (bus.occupancy_o[i] !== CW'(0)) $display("[TB] FAIL rec_occ%0d: got %0d want 0", i, bus.occupancy_o[i]);
            else pass_count++;
        end
        for (int i = 0; i < N; i++) bus.wbPacket_i[i] = mk(60 + i, i);
        tick();
        clear_inputs();
        tick();
        check_count++;
        if (bus.grant_o !== 4'b0100 || bus.wbPacket_o.seqNo !== 6'd62)
            $display("[TB] FAIL rec_rrptr: got grant %b seq %0d want 0100 seq 62", bus.grant_o, bus.wbPacket_o.seqNo);
        else pass_count++;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            clear_inputs();
            for (int l = 0; l < N; l++) if (m_q[l].size() < D) bus.wbPacket_i[l] = mk(40 + (c % 8), l);
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        check_count++;
        if (bus.wbPacket_o !== '0 || bus.grant_o !== 4'b0000)
            $display("[TB] FAIL areset_out: got %h/%b want 0/0000", bus.wbPacket_o, bus.grant_o);
        else pass_count++;
        check_count++;
        if (bus.ready_o !== 4'b1111) $display("[TB] FAIL areset_ready: got %b want 1111", bus.ready_o);
        else pass_count++;
        for (int i = 0; i < N; i++) begin
            check_count++;
            if (bus.occupancy_o[i] !== CW'(0)) $display("[TB] FAIL areset_occ%0d: got %0d want 0", i, bus.occupancy_o[i]);
            else pass_count++;
        end
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_count++;
            if (bus.wbPacket_o !== '0) $display("[TB] FAIL areset_stale%0d: got %h want 0", c, bus.wbPacket_o);
            else pass_count++;
        end
    endtask

    task automatic test_drop();
        int guard = 0;
        do_reset();
        while (m_q[3].size() < D && guard < 20) begin
            clear_inputs();
            for (int l = 0; l < N; l++) if (m_q[l].size() < D) bus.wbPacket_i[l] = mk(guard % 32, l);
            tick();
            guard++;
        end
        check_count++;
        if (guard >= 20) $display("[TB] FAIL drop_fill: got %0d cycles want lane 3 full before 20", guard);
        else pass_count++;
        check_count++;
        if (bus.ready_o[3] !== 1'b0) $display("[TB] FAIL drop_ready3: got %b want 0", bus.ready_o[3]);
        else pass_count++;
        clear_inputs();
        for (int l = 0; l < 3; l++) if (m_q[l].size() < D) bus.wbPacket_i[l] = mk(33 + l, l);
        bus.wbPacket_i[3] = mk(63, 3);
        tick();
        clear_inputs();
        for (int c = 0; c < 12; c++) begin
            check_count++;
            if (bus.wbPacket_o !== m_out || bus.grant_o !== m_grant)
                $display("[TB] FAIL drop_out%0d: got %h/%b want %h/%b", c, bus.wbPacket_o, bus.grant_o, m_out, m_grant);
            else pass_count++;
            for (int i = 0; i < N; i++) begin
                check_count++;
                if (bus.occupancy_o[i] !== CW'(m_q[i].size()))
                    $display("[TB] FAIL drop_occ%0d: got %0d want %0d", i, bus.occupancy_o[i], m_q[i].size());
                else pass_count++;
            end
            tick();
        end
    endtask

    task automatic test_random();
        wbPkt         p;
        logic [N-1:0] want_ready;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            clear_inputs();
            for (int i = 0; i < N; i++) begin
                if (m_q[i].size() < D && $urandom_range(0, 1) == 1) begin
                    p          = mk(int'($urandom_range(0, 62)), i);
                    p.data     = $urandom;
                    bus.wbPacket_i[i] = p;
                end
            end
            bus.recoverFlag_i = ($urandom_range(0, 39) == 0);
            tick();
            for (int i = 0; i < N; i++) want_ready[i] = (m_q[i].size() < D);
            check_count++;
            if (bus.wbPacket_o !== m_out)
                $display("[TB] FAIL rand_pkt@%0d: got %h want %h", cyc, bus.wbPacket_o, m_out);
            else pass_count++;
            check_count++;
            if (bus.grant_o !== m_grant)
                $display("[TB] FAIL rand_grant@%0d: got %b want %b", cyc, bus.grant_o, m_grant);
            else pass_count++;
            check_count++;
            if (bus.ready_o !== want_ready)
                $display("[TB] FAIL rand_ready@%0d: got %b want %b", cyc, bus.ready_o, want_ready);
            else pass_count++;
            for (int i = 0; i < N; i++) begin
                check_count++;
                if (bus.occupancy_o[i] !== CW'(m_q[i].size()))
                    $display("[TB] FAIL rand_occ%0d@%0d: got %0d want %0d", i, cyc, bus.occupancy_o[i], m_q[i].size());
                else pass_count++;
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_single_latency();
        test_all_lanes();
        test_backpressure();
        test_recovery();
        test_async_reset();
        test_drop();
        test_random();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of functional-unit lanes sharing one writeback port (2..8).
REQ-002 SHALL have parameter BUF_DEPTH, default 2: per-lane skid buffer entries (power of two, 2..4).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port recoverFlag_i  input  1  branch/exception recovery flush.
REQ-006 SHALL have port wbPacket_i  input  NUM_REQ x wbPkt  per-lane writeback request; .valid qualifies.
REQ-007 SHALL have port ready_o  output  NUM_REQ  lane i may present a valid packet this cycle.
REQ-008 SHALL have port wbPacket_o  output  wbPkt  registered, arbitrated packet to the shared writeback stage.
REQ-009 SHALL have port grant_o  output  NUM_REQ  registered one-hot lane index of wbPacket_o; zero when wbPacket_o.valid=0.
REQ-010 SHALL have port occupancy_o  output  NUM_REQ x clog2(BUF_DEPTH+1)  per-lane buffer fill count.

Function
REQ-011 SHALL enqueue wbPacket_i[i] into lane-i FIFO when wbPacket_i[i].valid & ready_o[i] & ~recoverFlag_i.
REQ-012 SHALL drive ready_o[i] = (occupancy[i] < BUF_DEPTH), from state only; a full lane is not ready even if dequeuing the same cycle.
REQ-013 SHALL silently drop a valid packet presented while ready_o[i]=0; this is a protocol violation flagged by a SIM-only assertion.
REQ-014 SHALL select each cycle, combinationally, one non-empty lane head by round-robin starting at lane (rrPtr+1) mod NUM_REQ.
REQ-015 SHALL dequeue the selected head and register it into wbPacket_o/grant_o at the same edge; rrPtr updates to the granted index.
REQ-016 SHALL leave rrPtr unchanged when no lane is non-empty.
REQ-017 SHALL give latency of exactly 2 cycles from input valid (cycle t) to wbPacket_o valid (cycle t+2) for an uncontended lane with empty FIFO.
REQ-018 SHALL guarantee a non-empty lane head is granted within NUM_REQ cycles (starvation bound).
REQ-019 SHALL sustain one output packet per cycle while any lane is non-empty.
REQ-020 SHALL handle enqueue and dequeue on the same lane in the same cycle, occupancy unchanged, FIFO order preserved.
REQ-021 SHALL wrap FIFO read/write pointers modulo BUF_DEPTH.
REQ-022 SHALL drive wbPacket_o to all-zero whenever no grant occurs (never stale data with valid=0).
REQ-023 SHALL, on recoverFlag_i=1, at that edge empty every FIFO, zero wbPacket_o and grant_o, ignore that cycle's inputs, and preserve rrPtr.
REQ-024 SHALL show ready_o all-ones in the cycle after a recovery.

Reset
REQ-025 SHALL on reset asynchronously clear all FIFOs and pointers, rrPtr=NUM_REQ-1 (lane 0 first), wbPacket_o=0, grant_o=0, occupancy_o=0, ready_o all-ones.
REQ-026 SHALL discard in-flight packets when reset asserts mid-operation; no output valid until two cycles after deassertion plus a new input.

Structure
REQ-027 SHALL place NUM_WB_REQ and WB_ARB_BUF_DEPTH constants in the shared package; wbPkt remains the existing package typedef.
REQ-028 SHALL instantiate one sub-module wb_arb_fifo (BUF_DEPTH-entry wbPkt FIFO with count, flush, async reset) per lane.
REQ-029 SHALL keep the round-robin arbiter and output register in wb_port_arbiter itself.

Verification
REQ-030 SHALL cover: after reset, lane 2 sends seqNo=5 at cycle 3 -> wbPacket_o.seqNo=5, grant_o=0100 at cycle 5.
REQ-031 SHALL cover: all 4 lanes valid at cycle 0 (seqNo 10..13) -> outputs at cycles 2,3,4,5 in order lane0,1,2,3.
REQ-032 SHALL cover: lane 1 sends 3 back-to-back while lanes 0,2 saturate -> ready_o[1]=0 after 2 accepted, lane-1 packets emitted in order, each within 4 cycles of reaching head.
REQ-033 SHALL cover: recoverFlag_i at cycle 4 with occupancy {2,1,2,0} -> cycle 5 wbPacket_o=0, occupancy_o all 0, ready_o=1111, next grant follows preserved rrPtr.
REQ-034 SHALL cover: reset asserted asynchronously mid-burst -> outputs zero immediately, no pre-reset packet ever emitted.
REQ-035 SHALL cover: lane 3 full, enqueue attempted with ready_o[3]=0 -> packet dropped, assertion fires, other lanes unaffected.
